// File: rtl/modulus_chunk_sequencer.sv
// Steps a shared modulus chunk LUT through the upper chunks of a product, LSB chunk
// first, and flags the cycles in which the LUT's moduli_terms are valid downstream.
module modulus_chunk_sequencer #(
    parameter int BIT_LEN    = 15,
    parameter int NUM_CHUNKS = 8,
    parameter int IDX_W      = $clog2(NUM_CHUNKS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_bypass,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CHUNKS*BIT_LEN-1:0]  in_upper,
    output logic [BIT_LEN-1:0]             lut_addr,
    output logic                           lut_ce,
    output logic                           lut_bypass,
    output logic                           term_valid,
    input  logic                           term_ready,
    output logic [IDX_W-1:0]               term_idx,
    output logic                           term_last,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t                          state;
    logic [NUM_CHUNKS*BIT_LEN-1:0]   shift_p0;
    logic                            mode;
    logic                            bypass_q;
    logic [IDX_W-1:0]                cnt;
    logic                            vld_p1;
    logic [IDX_W-1:0]                idx_p1;

    logic accept;
    logic issue;
    logic advance;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Registered LUT: issue only when the output register is free or being drained.
    // Bypass LUT: the term is live while presented, so advance on consumption.
    assign issue    = (state == ISSUE) && !mode && (!vld_p1 || term_ready);
    assign advance  = issue || ((state == ISSUE) && mode && term_ready);

    assign lut_addr   = shift_p0[BIT_LEN-1:0];
    assign lut_ce     = issue;
    assign lut_bypass = bypass_q;
    assign term_valid = mode ? (state == ISSUE) : vld_p1;
    assign term_idx   = mode ? cnt : idx_p1;
    assign term_last  = term_valid && (term_idx == LAST_IDX);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift_p0 <= '0;
            mode     <= 1'b0;
            bypass_q <= 1'b0;
            cnt      <= '0;
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
        end else begin
            // p0 -> p1: LUT output register stage, mirrored by vld_p1/idx_p1
            if (issue) begin
                vld_p1 <= 1'b1;
                idx_p1 <= cnt;
            end else if (term_ready) begin
                vld_p1 <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_p0 <= in_upper;
                        mode     <= cfg_bypass;
                        bypass_q <= cfg_bypass;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (advance) begin
                        shift_p0 <= shift_p0 >> BIT_LEN;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            if (mode) begin
                                state    <= DONE;
                                bypass_q <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (vld_p1 && term_ready) begin
                        state    <= DONE;
                        bypass_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulus_chunk_sequencer.sv
// Directed bench for modulus_chunk_sequencer with four 15-bit chunks per operation.
module tb_modulus_chunk_sequencer;

    localparam int BL = 15;
    localparam int NC = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_bypass;
    logic              in_valid;
    logic              in_ready;
    logic [NC*BL-1:0]  in_upper;
    logic [BL-1:0]     lut_addr;
    logic              lut_ce;
    logic              lut_bypass;
    logic              term_valid;
    logic              term_ready;
    logic [IW-1:0]     term_idx;
    logic              term_last;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    modulus_chunk_sequencer #(.BIT_LEN(BL), .NUM_CHUNKS(NC)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_bypass (cfg_bypass),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_upper   (in_upper),
        .lut_addr   (lut_addr),
        .lut_ce     (lut_ce),
        .lut_bypass (lut_bypass),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_idx   (term_idx),
        .term_last  (term_last),
        .busy       (busy),
        .done       (done)
    );

    localparam logic [NC*BL-1:0] W1 = {15'h0004, 15'h0003, 15'h0002, 15'h0001};
    localparam logic [NC*BL-1:0] WB = {15'h0005, 15'h1234, 15'h0000, 15'h7FFF};
    localparam logic [NC*BL-1:0] W3 = {15'h000D, 15'h000C, 15'h000B, 15'h000A};
    localparam logic [NC*BL-1:0] W4 = {15'h7FFF, 15'h4000, 15'h0001, 15'h2AAA};
    localparam logic [NC*BL-1:0] W5 = {15'h0011, 15'h0022, 15'h0033, 15'h0044};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        #1;
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".lut_ce"}, lut_ce, 0);
        check({tag, ".lut_addr"}, lut_addr, 0);
        check({tag, ".lut_bypass"}, lut_bypass, 0);
        check({tag, ".term_valid"}, term_valid, 0);
        check({tag, ".term_idx"}, term_idx, 0);
        check({tag, ".term_last"}, term_last, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
    endtask

    task automatic exp_cyc(input string tag, input logic ce, input logic [BL-1:0] addr,
                           input logic tv, input logic [IW-1:0] idx, input logic last,
                           input logic dn, input logic byp);
        #1;
        check({tag, ".lut_ce"}, lut_ce, ce);
        check({tag, ".lut_addr"}, lut_addr, addr);
        check({tag, ".term_valid"}, term_valid, tv);
        if (tv) begin
            check({tag, ".term_idx"}, term_idx, idx);
            check({tag, ".lut_bypass"}, lut_bypass, byp);
        end
        check({tag, ".term_last"}, term_last, last);
        check({tag, ".done"}, done, dn);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".in_ready"}, in_ready, 0);
    endtask

    // Registered-mode timeline for cycle T+k with term_ready held high.
    task automatic reg_exp(input string tag, input int k, input logic [NC*BL-1:0] w);
        logic [BL-1:0] a;
        a = '0;
        if (k >= 1 && k <= NC) a = w[(k-1)*BL +: BL];
        exp_cyc($sformatf("%s.k%0d", tag, k), (k <= NC), a, (k >= 2 && k <= NC+1),
                IW'(k-2), (k == NC+1), (k == NC+2), 1'b0);
    endtask

    // Bypass-mode timeline for cycle T+k with term_ready held high.
    task automatic byp_exp(input string tag, input int k, input logic [NC*BL-1:0] w);
        if (k <= NC)
            exp_cyc($sformatf("%s.k%0d", tag, k), 1'b0, w[(k-1)*BL +: BL], 1'b1,
                    IW'(k-1), (k == NC), 1'b0, 1'b1);
        else
            exp_cyc($sformatf("%s.k%0d", tag, k), 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // Called in the accept cycle T; returns in the done cycle.
    task automatic reg_seq(input string tag, input logic [NC*BL-1:0] w, input logic hold_valid);
        #1;
        check({tag, ".accept_ready"}, in_ready, 1);
        for (int k = 1; k <= NC+2; k++) begin
            tick();
            if (k == 1) begin
                in_valid = hold_valid;
                in_upper = ~w;
            end
            reg_exp(tag, k, w);
        end
    endtask

    task automatic byp_seq(input string tag, input logic [NC*BL-1:0] w);
        #1;
        check({tag, ".accept_ready"}, in_ready, 1);
        for (int k = 1; k <= NC+1; k++) begin
            tick();
            if (k == 1) begin
                in_valid   = 1'b0;
                in_upper   = ~w;
                cfg_bypass = 1'b0;
            end
            byp_exp(tag, k, w);
        end
    endtask

    task automatic back_idle(input string tag);
        tick();
        #1;
        check({tag, ".idle_ready"}, in_ready, 1);
        check({tag, ".idle_done"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        cfg_bypass = 1'b0;
        in_valid   = 1'b0;
        in_upper   = '0;
        term_ready = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero($sformatf("rst%0d", i));
        end
        reset = 1'b0;
        #1;
        check("post_rst.in_ready", in_ready, 1);
        term_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("idle%0d.lut_ce", i), lut_ce, 0);
            check($sformatf("idle%0d.term_valid", i), term_valid, 0);
            check($sformatf("idle%0d.done", i), done, 0);
        end

        // Registered mode, no stall
        in_valid = 1'b1; in_upper = W1; cfg_bypass = 1'b0;
        reg_seq("reg", W1, 1'b0);
        back_idle("reg");

        // Registered mode with a 3-cycle stall on idx1
        in_valid = 1'b1; in_upper = W1;
        #1;
        check("stall.accept_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        exp_cyc("stall.k1", 1, 15'h1, 0, 0, 0, 0, 0);
        tick();
        exp_cyc("stall.k2", 1, 15'h2, 1, 0, 0, 0, 0);
        tick(); term_ready = 1'b0;
        exp_cyc("stall.k3", 0, 15'h3, 1, 1, 0, 0, 0);
        tick();
        exp_cyc("stall.k4", 0, 15'h3, 1, 1, 0, 0, 0);
        tick();
        exp_cyc("stall.k5", 0, 15'h3, 1, 1, 0, 0, 0);
        tick(); term_ready = 1'b1;
        exp_cyc("stall.k6", 1, 15'h3, 1, 1, 0, 0, 0);
        tick();
        exp_cyc("stall.k7", 1, 15'h4, 1, 2, 0, 0, 0);
        tick();
        exp_cyc("stall.k8", 0, 15'h0, 1, 3, 1, 0, 0);
        tick();
        exp_cyc("stall.k9", 0, 15'h0, 0, 0, 0, 1, 0);
        back_idle("stall");

        // Bypass mode; cfg_bypass drops right after accept
        in_valid = 1'b1; in_upper = WB; cfg_bypass = 1'b1;
        byp_seq("byp", WB);
        back_idle("byp");

        // Reset while idx2 is valid, then a fresh operation
        in_valid = 1'b1; in_upper = W1; cfg_bypass = 1'b0;
        #1;
        check("abort.accept_ready", in_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            reg_exp("abort", k, W1);
        end
        reset = 1'b1;
        tick();
        chk_zero("abort.rst");
        reset = 1'b0;
        #1;
        check("abort.ready", in_ready, 1);
        check("abort.no_done", done, 0);
        in_valid = 1'b1; in_upper = W5; cfg_bypass = 1'b1;
        byp_seq("fresh", W5);
        back_idle("fresh");

        // Back-to-back with in_valid held high
        in_valid = 1'b1; in_upper = W3; cfg_bypass = 1'b0;
        reg_seq("b2b_a", W3, 1'b1);
        tick();
        in_upper = W4;
        #1;
        check("b2b.second_accept_ready", in_ready, 1);
        check("b2b.second_accept_busy", busy, 0);
        reg_seq("b2b_b", W4, 1'b0);
        back_idle("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
